// File: rtl/cache_req_sequencer.sv
// Cache interface master: queues trace requests in a small FIFO, holds each on the
// cache bus for CAS_LATENCY cycles, then emits one response pulse per request.
module cache_req_sequencer #(
    parameter int WORD_W      = 8,
    parameter int ADDR_W      = 32,
    parameter int OP_W        = 4,
    parameter int DEPTH       = 4,
    parameter int CAS_LATENCY = 1,
    parameter logic [OP_W-1:0] NOP_OP = OP_W'(4'hF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [WORD_W-1:0] in_data,
    output logic [OP_W-1:0]   cache_op,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [WORD_W-1:0] cache_data_out,
    output logic              cache_data_oe,
    input  logic [WORD_W-1:0] cache_data_in,
    output logic              rsp_valid,
    output logic [OP_W-1:0]   rsp_op,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [WORD_W-1:0] rsp_data,
    output logic              busy
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int HW   = (CAS_LATENCY > 1) ? $clog2(CAS_LATENCY) : 1;

    localparam logic [OP_W-1:0] OP_READ   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_WRITE  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_IFETCH = OP_W'(2);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state, next_state;

    logic [OP_W-1:0]   fifo_op   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [WORD_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   count;

    logic [OP_W-1:0]   req_op;
    logic [WORD_W-1:0] req_data;
    logic [ADDR_W-1:0] addr_reg;
    logic [WORD_W-1:0] rsp_data_reg;
    logic [HW-1:0]     hold;

    logic push, pop, req_is_read, req_is_write;

    assign in_ready     = (count < CNTW'(DEPTH)) && !reset;
    assign push         = in_valid && in_ready;
    assign req_is_read  = (req_op == OP_READ) || (req_op == OP_IFETCH);
    assign req_is_write = (req_op == OP_WRITE);

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (hold == '0) next_state = RESP;
            end
            RESP: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Storage array carries no reset; entries are only meaningful below count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_op[wr_ptr]   <= in_op;
            fifo_addr[wr_ptr] <= in_addr;
            fifo_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            req_op       <= '0;
            req_data     <= '0;
            addr_reg     <= '0;
            rsp_data_reg <= '0;
            hold         <= '0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                req_op   <= fifo_op[rd_ptr];
                req_data <= fifo_data[rd_ptr];
                addr_reg <= fifo_addr[rd_ptr];
                hold     <= HW'(CAS_LATENCY - 1);
            end else if (state == ISSUE && hold != '0) begin
                hold <= hold - HW'(1);
            end
            // Read data is valid on the bus at the edge closing the last hold cycle.
            if (state == ISSUE && hold == '0) begin
                if (req_is_read)       rsp_data_reg <= cache_data_in;
                else if (req_is_write) rsp_data_reg <= req_data;
                else                   rsp_data_reg <= '0;
            end
        end
    end

    assign cache_op       = (state == ISSUE) ? req_op : NOP_OP;
    assign cache_addr     = addr_reg;
    assign cache_data_oe  = (state == ISSUE) && req_is_write;
    assign cache_data_out = cache_data_oe ? req_data : '0;

    assign rsp_valid = (state == RESP);
    assign rsp_op    = rsp_valid ? req_op : '0;
    assign rsp_addr  = rsp_valid ? addr_reg : '0;
    assign rsp_data  = rsp_valid ? rsp_data_reg : '0;

    assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Scoreboard bench for cache_req_sequencer (DEPTH=4, CAS_LATENCY=3): requests are
// queued on acceptance and checked against the bus and the response port.
module tb_cache_req_sequencer;

    localparam int CAS = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_addr;
    logic [7:0]  in_data;
    logic [3:0]  cache_op;
    logic [31:0] cache_addr;
    logic [7:0]  cache_data_out, cache_data_in;
    logic        cache_data_oe;
    logic        rsp_valid;
    logic [3:0]  rsp_op;
    logic [31:0] rsp_addr;
    logic [7:0]  rsp_data;
    logic        busy;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } req_t;

    req_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   run = 0;
    int   cyc = 0;
    int   last_start = 0;
    int   starts = 0;
    bit   mixed_mode = 0;
    bit   saw_backpressure = 0;

    cache_req_sequencer #(
        .WORD_W(8), .ADDR_W(32), .OP_W(4), .DEPTH(4), .CAS_LATENCY(CAS), .NOP_OP(4'hF)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_data(in_data),
        .cache_op(cache_op), .cache_addr(cache_addr),
        .cache_data_out(cache_data_out), .cache_data_oe(cache_data_oe),
        .cache_data_in(cache_data_in),
        .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] rd_val(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB5;
    endfunction

    function automatic logic [7:0] exp_rsp_data(input req_t r);
        if (r.op == 4'd0 || r.op == 4'd2) return rd_val(r.addr);
        if (r.op == 4'd1) return r.wdata;
        return 8'h00;
    endfunction

    // Memory model: returns address-derived read data unless we are driving the bus.
    assign cache_data_in = cache_data_oe ? cache_data_out : rd_val(cache_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic waitCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [7:0] data);
        int waited = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_data  = data;
        while (!in_ready && waited < 200) begin
            saw_backpressure = 1'b1;
            waitCycle();
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        else waitCycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            waitCycle();
            n++;
        end
        checkOutput("drain_idle", 32'(busy), 32'd0);
        checkOutput("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: bus contents, hold length, responses and scoreboard pushes.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            run = 0;
        end else begin
            if (cache_op != 4'hF) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    if (run == 0) begin
                        if (mixed_mode && starts > 0) checkOutput("b2b_gap", 32'(cyc - last_start), 32'(CAS + 1));
                        starts++;
                        last_start = cyc;
                    end
                    checkOutput("issue_op", 32'(cache_op), 32'(exp_q[0].op));
                    checkOutput("issue_addr", cache_addr, exp_q[0].addr);
                    checkOutput("issue_oe", 32'(cache_data_oe), 32'(exp_q[0].op == 4'd1));
                    if (exp_q[0].op == 4'd1) checkOutput("issue_wdata", 32'(cache_data_out), 32'(exp_q[0].wdata));
                end
                run++;
            end else begin
                checkOutput("idle_oe", 32'(cache_data_oe), 32'd0);
                if (run > 0) begin
                    checkOutput("issue_len", 32'(run), 32'(CAS));
                    checkOutput("rsp_after_issue", 32'(rsp_valid), 32'd1);
                    run = 0;
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    checkOutput("rsp_op", 32'(rsp_op), 32'(e.op));
                    checkOutput("rsp_addr", rsp_addr, e.addr);
                    checkOutput("rsp_data", 32'(rsp_data), 32'(exp_rsp_data(e)));
                end
            end
            if (in_valid && in_ready) begin
                req_t r;
                r.op = in_op;
                r.addr = in_addr;
                r.wdata = in_data;
                exp_q.push_back(r);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_addr  = 32'h0000_0055;
        in_data  = 8'h11;

        // Reset held with a request offered: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            waitCycle();
            checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
            checkOutput("rst_cache_op", 32'(cache_op), 32'hF);
            checkOutput("rst_oe", 32'(cache_data_oe), 32'd0);
            checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
        end
        checkOutput("rst_cache_addr", cache_addr, 32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        waitCycle();
        waitCycle();
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_cache_op", 32'(cache_op), 32'hF);

        // Single read: issue window k+2..k+1+CAS, response at k+2+CAS.
        applyStimulus(4'd0, 32'h0000_1000, 8'h00);
        checkOutput("rd_wait_op", 32'(cache_op), 32'hF);
        checkOutput("rd_busy", 32'(busy), 32'd1);
        waitCycle();
        for (int i = 0; i < CAS; i++) begin
            checkOutput("rd_issue_op", 32'(cache_op), 32'd0);
            checkOutput("rd_issue_addr", cache_addr, 32'h0000_1000);
            checkOutput("rd_no_rsp", 32'(rsp_valid), 32'd0);
            waitCycle();
        end
        checkOutput("rd_end_op", 32'(cache_op), 32'hF);
        checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rd_rsp_data", 32'(rsp_data), 32'hA5);
        waitCycle();
        checkOutput("rd_pulse", 32'(rsp_valid), 32'd0);
        checkOutput("rd_idle", 32'(busy), 32'd0);
        checkOutput("rd_addr_hold", cache_addr, 32'h0000_1000);

        // Write: bus driven for exactly CAS cycles, echoed in the response.
        applyStimulus(4'd1, 32'hDEAD_BEE0, 8'h3C);
        waitCycle();
        for (int i = 0; i < CAS; i++) begin
            checkOutput("wr_oe", 32'(cache_data_oe), 32'd1);
            checkOutput("wr_data_out", 32'(cache_data_out), 32'h3C);
            waitCycle();
        end
        checkOutput("wr_oe_off", 32'(cache_data_oe), 32'd0);
        checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("wr_rsp_data", 32'(rsp_data), 32'h3C);
        drain();

        // Six consecutive pushes against a 4-deep FIFO.
        saw_backpressure = 1'b0;
        for (int i = 0; i < 6; i++)
            applyStimulus(4'(i % 3), 32'h0000_4000 + 32'(i * 4), 8'(8'h80 + i));
        checkOutput("fifo_backpressure", 32'(saw_backpressure), 32'd1);
        drain();

        // Mixed ops queued back to back.
        mixed_mode = 1'b1;
        starts     = 0;
        applyStimulus(4'd2, 32'h0000_5010, 8'hAA);
        applyStimulus(4'd3, 32'h0000_5020, 8'hBB);
        applyStimulus(4'd8, 32'h0000_5030, 8'hCC);
        applyStimulus(4'd9, 32'h0000_5040, 8'hDD);
        drain();
        checkOutput("mixed_issue_count", 32'(starts), 32'd4);
        mixed_mode = 1'b0;

        // Reset in the second hold cycle with two entries queued behind it.
        applyStimulus(4'd0, 32'h0000_2000, 8'h00);
        applyStimulus(4'd1, 32'h0000_2004, 8'h77);
        applyStimulus(4'd3, 32'h0000_2008, 8'h00);
        checkOutput("mid_in_issue", 32'(cache_op), 32'd0);
        reset = 1'b1;
        waitCycle();
        reset = 1'b0;
        checkOutput("mid_cache_op", 32'(cache_op), 32'hF);
        checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_oe", 32'(cache_data_oe), 32'd0);
        for (int i = 0; i < 6; i++) begin
            waitCycle();
            checkOutput("mid_quiet_rsp", 32'(rsp_valid), 32'd0);
            checkOutput("mid_quiet_busy", 32'(busy), 32'd0);
        end
        applyStimulus(4'd0, 32'h0000_3000, 8'h00);
        applyStimulus(4'd1, 32'h0000_3004, 8'h5E);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_req_sequencer.md
# cache_req_sequencer

Upstream driver for the cache interface master side. Accepts cache requests (operation, address, data) from the trace front end into a small FIFO, issues them one at a time on the cache interface, holds each for the cache's CAS latency, and returns one response per request, including captured read data. It replaces ad-hoc testbench driving of the master modport with a clocked, back-pressured request stage.

## Interface
- WORD_W, 8, data word width
- ADDR_W, 32, address width
- OP_W, 4, operation code width (cache package op codes)
- DEPTH, 4, request FIFO entries; power of two, ≥2
- CAS_LATENCY, 1, cycles each op is held on the cache bus before data is valid; ≥1
- NOP_OP, 4'hF, op value driven when no request is active

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request offered
- in_ready  out  1  FIFO can accept this cycle
- in_op  in  OP_W  request op code
- in_addr  in  ADDR_W  request address
- in_data  in  WORD_W  write data (ignored for non-write ops)
- cache_op  out  OP_W  operation to cache
- cache_addr  out  ADDR_W  address to cache
- cache_data_out  out  WORD_W  write data to shared data bus
- cache_data_oe  out  1  drive enable for shared data bus
- cache_data_in  in  WORD_W  data bus as seen from this side
- rsp_valid  out  1  one-cycle response pulse
- rsp_op  out  OP_W  op of completed request
- rsp_addr  out  ADDR_W  address of completed request
- rsp_data  out  WORD_W  read data / echoed write data / 0
- busy  out  1  FIFO non-empty or request in flight

## Operation
- Op classes: read-like = 0 (data read), 2 (instruction fetch); write = 1; all other codes = no-data.
- FIFO: push when in_valid && in_ready; in_ready = (count < DEPTH) && !reset. Pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged. When full, in_ready=0 even if a pop occurs that cycle.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: FIFO non-empty → pop head into request register, load hold counter = CAS_LATENCY-1, → ISSUE. Else stay.
  - ISSUE: drive cache_op/addr from request register; cache_data_oe=1 and cache_data_out=request data only for write. Counter decrements each cycle; in the cycle where counter==0, sample cache_data_in (read-like) at that edge, → RESP.
  - RESP: cache_op=NOP_OP, oe=0, rsp_valid=1 with rsp fields. If FIFO non-empty, pop and → ISSUE (back-to-back); else → IDLE.
- rsp_data: read-like = sampled cache_data_in; write = request data; no-data = 0.
- Outside ISSUE: cache_op=NOP_OP, cache_addr holds last value, cache_data_oe=0.
- busy = (state != IDLE) || (count != 0).
- Unknown op codes are passed through as no-data, never dropped.

## Timing
- Reset (synchronous): state=IDLE, FIFO emptied, count=0; cache_op=NOP_OP, cache_addr=0, cache_data_out=0, cache_data_oe=0, rsp_valid=0, rsp_op=0, rsp_addr=0, rsp_data=0, busy=0, in_ready=0 while reset high and 1 the cycle after.
- Reset mid-operation: in-flight request and queued entries discarded, no rsp_valid generated, bus released the cycle after reset sampled.
- Latency: accepted at cycle k into empty idle block → cache_op valid cycles k+2 … k+1+CAS_LATENCY → rsp_valid at cycle k+2+CAS_LATENCY.
- Back-to-back throughput: one request per CAS_LATENCY+1 cycles; cache_op returns to NOP_OP for exactly one cycle (RESP) between requests.
- cache_op, cache_addr, cache_data_out stable for all CAS_LATENCY cycles of a request.
- rsp_valid is a single-cycle pulse; no downstream back-pressure.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 → in_ready=0, cache_op=4'hF, oe=0, rsp_valid=0, busy=0; no entry queued.
- Single read, CAS_LATENCY=1: push op 0, addr 32'h0000_1000 at cycle 5; bench drives cache_data_in=8'hA5 → cache_op=0 in cycle 7 only, rsp_valid at cycle 8 with rsp_data=8'hA5.
- Write, CAS_LATENCY=3: push op 1, addr 32'hDEAD_BEE0, data 8'h3C → oe=1 and data_out=8'h3C for exactly 3 cycles, rsp_data=8'h3C, oe=0 afterwards.
- FIFO full/back-pressure, DEPTH=4: push 6 requests on consecutive cycles while first is in flight → in_ready drops when count=4, all accepted requests issued in order, 6 responses with matching addresses, no loss or duplication.
- Mixed ops back-to-back: ops 2,3,8,9 queued → each issued, NOP_OP one cycle between, responses for 3/8/9 have rsp_data=0, oe never asserted.
- Reset during ISSUE with 2 queued: assert reset in second hold cycle → no rsp_valid, cache_op=4'hF next cycle, busy=0, later push processed normally.
